// File: rtl/multiply_seq_if.sv
// multiply_seq_if: operand/result handshake bundle for multiply_seq.
//   in_valid/in_ready  operand handshake (a, b, is_signed qualified by in_valid)
//   out_valid/out_ready result handshake (p qualified by out_valid)
//   busy               multiplier is iterating
// Modports: master = operand producer / result consumer, slave = multiplier.
interface multiply_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/multiply_seq.sv
// multiply_seq: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multiply_seq_if slave: operand handshake, result handshake, busy
// Latency is WIDTH cycles from accept to out_valid; no early exit on zero operands.
module multiply_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    multiply_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] sh_a_q, sh_a_d;   // mag_a pre-shifted by (WIDTH - count)
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] sum;

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        p_d     = p_q;

        // Negating the most negative value wraps to 2^(WIDTH-1), which is the
        // correct unsigned magnitude.
        abs_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        sum   = acc_q + (mag_b_q[0] ? sh_a_q : '0);

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StRun;
                    neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    sh_a_d  = {{WIDTH{1'b0}}, abs_a};
                    mag_b_d = abs_b;
                    acc_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                end
            end
            StRun: begin
                acc_d   = sum;
                sh_a_d  = sh_a_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    p_d     = neg_q ? -sum : sum;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun);
    assign bus.p         = p_q;
endmodule

// File: tb/tb_multiply_seq.sv
// Bench for multiply_seq at WIDTH = 8, 4 and 16 against an integer reference product.
module tb_multiply_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multiply_seq_if #(.WIDTH(8))  if8  ();
    multiply_seq_if #(.WIDTH(4))  if4  ();
    multiply_seq_if #(.WIDTH(16)) if16 ();

    multiply_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    multiply_seq #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    multiply_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as integers, multiply, reduce mod 2^(2w).
    function automatic longint unsigned ref_prod(input int w, input longint unsigned a,
                                                 input longint unsigned b, input bit s);
        longint sa, sb, pr;
        longint unsigned mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        pr   = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return longint'(pr) & mask;
    endfunction

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                        output logic [15:0] res, output int lat, output int bn);
        @(posedge clk); #1;
        if8.a = ia; if8.b = ib; if8.is_signed = is; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        lat = 0;
        bn  = int'(if8.busy);
        while (!if8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bn += int'(if8.busy);
        end
        res = if8.p;
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic is,
                        output logic [7:0] res, output int lat);
        @(posedge clk); #1;
        if4.a = ia; if4.b = ib; if4.is_signed = is; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if4.p;
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                         output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        if16.a = ia; if16.b = ib; if16.is_signed = is; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if16.p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({if8.in_ready, if8.out_valid, if8.busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctrl got in_ready/out_valid/busy=%b want 100",
                     {if8.in_ready, if8.out_valid, if8.busy});
        end
        total++;
        if (if8.p !== 16'h0) begin
            bad++;
            $display("FAIL reset_p8 got %h want 0000", if8.p);
        end
        total++;
        if (if16.p !== 32'h0 || if16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_w16 got p=%h out_valid=%b want 0/0", if16.p, if16.out_valid);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_unsigned_max();
        logic [15:0] res;
        int lat, bn;
        run8(8'hFF, 8'hFF, 1'b0, res, lat, bn);
        total++;
        if (res !== 16'hFE01) begin
            bad++;
            $display("FAIL umax_p got %h want fe01", res);
        end
        total++;
        if (lat != 8) begin
            bad++;
            $display("FAIL umax_latency got %0d want 8", lat);
        end
        total++;
        if (bn != 8) begin
            bad++;
            $display("FAIL umax_busy_cycles got %0d want 8", bn);
        end
    endtask

    task automatic test_signed_cases();
        logic [7:0]  ta [4] = '{8'h80, 8'h80, 8'h03, 8'h00};
        logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'hFB, 8'hFF};
        logic [15:0] tp [4] = '{16'h4000, 16'hC080, 16'hFFF1, 16'h0000};
        logic [15:0] res;
        int lat, bn;
        for (int i = 0; i < 4; i++) begin
            run8(ta[i], tb[i], 1'b1, res, lat, bn);
            total++;
            if (res !== tp[i] || lat != 8) begin
                bad++;
                $display("FAIL signed_case%0d a=%h b=%h got p=%h lat=%0d want p=%h lat=8",
                         i, ta[i], tb[i], res, lat, tp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
        if8.a = 8'h12; if8.b = 8'h34; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (if8.p !== 16'h03A8 || lat != 8) begin
            bad++;
            $display("FAIL bp_first got p=%h lat=%0d want 03a8 lat=8", if8.p, lat);
        end
        // Different operands offered during the stall must be ignored.
        if8.a = 8'hFF; if8.b = 8'hFF; if8.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({if8.out_valid, if8.in_ready} !== 2'b10 || if8.p !== 16'h03A8) begin
                bad++;
                $display("FAIL bp_stall%0d got out_valid/in_ready=%b p=%h want 10 p=03a8",
                         c, {if8.out_valid, if8.in_ready}, if8.p);
            end
        end
        // Handshake edge with in_valid still high: back to IDLE, nothing accepted.
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        total++;
        if ({if8.out_valid, if8.in_ready, if8.busy} !== 3'b010) begin
            bad++;
            $display("FAIL bp_release got out_valid/in_ready/busy=%b want 010",
                     {if8.out_valid, if8.in_ready, if8.busy});
        end
        total++;
        if (if8.p !== 16'h03A8) begin
            bad++;
            $display("FAIL bp_p_held got %h want 03a8", if8.p);
        end
        @(posedge clk); #1;
        total++;
        if (if8.busy !== 1'b0 || if8.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_idle got busy=%b in_ready=%b want 0/1", if8.busy, if8.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int          acc_cyc [$];
        logic [15:0] expq [$];
        logic [15:0] e;
        longint unsigned r;
        int          nacc, nout;
        nacc = 0;
        nout = 0;
        @(posedge clk); #1;
        if8.out_ready = 1'b1;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            if (if8.out_valid) begin
                nout++;
                e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                total++;
                if (if8.p !== e) begin
                    bad++;
                    $display("FAIL b2b_p%0d got %h want %h", nout, if8.p, e);
                end
            end
            if (if8.in_ready) begin
                if (nacc < 5) begin
                    if8.a = 8'($urandom);
                    if8.b = 8'($urandom);
                    if8.is_signed = 1'($urandom);
                    if8.in_valid = 1'b1;
                    r = ref_prod(8, longint'(if8.a), longint'(if8.b), if8.is_signed);
                    e = r[15:0];
                    expq.push_back(e);
                    acc_cyc.push_back(c);
                    nacc++;
                end else begin
                    if8.in_valid = 1'b0;
                end
            end
        end
        if8.in_valid = 1'b0;
        total++;
        if (nacc != 5 || nout != 5) begin
            bad++;
            $display("FAIL b2b_counts got accepts=%0d outputs=%0d want 5/5", nacc, nout);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
                bad++;
                $display("FAIL b2b_interval%0d got %0d want 10", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] res;
        int lat, bn, spurious;
        @(posedge clk); #1;
        if8.a = 8'd100; if8.b = 8'd100; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (if8.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got busy=%b want 1", if8.busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({if8.in_ready, if8.out_valid, if8.busy} !== 3'b100 || if8.p !== 16'h0) begin
            bad++;
            $display("FAIL midrst_now got in_ready/out_valid/busy=%b p=%h want 100 p=0000",
                     {if8.in_ready, if8.out_valid, if8.busy}, if8.p);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            spurious += int'(if8.out_valid);
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL midrst_spurious got %0d out_valid cycles want 0", spurious);
        end
        run8(8'd7, 8'd6, 1'b0, res, lat, bn);
        total++;
        if (res !== 16'd42 || lat != 8) begin
            bad++;
            $display("FAIL midrst_next got p=%0d lat=%0d want 42 lat=8", res, lat);
        end
    endtask

    task automatic test_sweep4();
        logic [3:0] corner [3] = '{4'h0, 4'hF, 4'h8};
        logic [3:0] va, vb;
        logic [7:0] res, e;
        longint unsigned r;
        logic s;
        int lat;
        for (int k = 0; k < 38; k++) begin
            s = 1'(k % 2);
            if (k < 18) begin
                va = corner[(k / 2) % 3];
                vb = corner[(k / 6) % 3];
            end else begin
                va = 4'($urandom);
                vb = 4'($urandom);
            end
            run4(va, vb, s, res, lat);
            r = ref_prod(4, longint'(va), longint'(vb), s);
            e = r[7:0];
            total++;
            if (res !== e || lat != 4) begin
                bad++;
                $display("FAIL sweep4 a=%h b=%h s=%0d got p=%h lat=%0d want p=%h lat=4",
                         va, vb, s, res, lat, e);
            end
        end
    endtask

    task automatic test_sweep16();
        logic [15:0] corner [3] = '{16'h0000, 16'hFFFF, 16'h8000};
        logic [15:0] va, vb;
        logic [31:0] res, e;
        longint unsigned r;
        logic s;
        int lat;
        for (int k = 0; k < 38; k++) begin
            s = 1'(k % 2);
            if (k < 18) begin
                va = corner[(k / 2) % 3];
                vb = corner[(k / 6) % 3];
            end else begin
                va = 16'($urandom);
                vb = 16'($urandom);
            end
            run16(va, vb, s, res, lat);
            r = ref_prod(16, longint'(va), longint'(vb), s);
            e = r[31:0];
            total++;
            if (res !== e || lat != 16) begin
                bad++;
                $display("FAIL sweep16 a=%h b=%h s=%0d got p=%h lat=%0d want p=%h lat=16",
                         va, vb, s, res, lat, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.is_signed  = 1'b0;
        if8.out_ready = 1'b1;
        if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.is_signed  = 1'b0;
        if4.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.is_signed = 1'b0;
        if16.out_ready = 1'b1;

        test_reset();
        test_unsigned_max();
        test_signed_cases();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep4();
        test_sweep16();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multiply_seq.md
# multiply_seq

Parametrised iterative shift-add multiplier with valid/ready handshakes on both sides. It replaces the fixed 8x8 combinational array multiplier wherever area matters more than single-cycle latency. It supports unsigned and two's-complement operands, selected per operation. It sits between an operand producer and a result consumer; either side may stall.

## Interface
- WIDTH, default 8: operand width in bits (WIDTH >= 2). The product is 2*WIDTH bits.
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a, b and is_signed are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- is_signed  input  1  1 = both operands two's complement, 0 = both unsigned
- out_valid  output  1  p holds a completed product
- out_ready  input  1  consumer accepts p
- p  output  2*WIDTH  product
- busy  output  1  high in RUN state

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands and go to RUN.
  - Unsigned (is_signed = 0): mag_a = a, mag_b = b, neg = 0.
  - Signed (is_signed = 1): mag_a = |a|, mag_b = |b|, both as WIDTH-bit unsigned magnitudes; neg = a[WIDTH-1] ^ b[WIDTH-1].
  - The most negative value has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Clear the accumulator to 0 and load the step counter with WIDTH.
- RUN:
  - Each cycle, if the multiplier LSB is 1, add mag_a shifted left by (WIDTH - count) into the 2*WIDTH-bit accumulator.
  - Shift the multiplier right by 1 and decrement the counter.
  - The final addition happens on the edge where the counter goes 1 -> 0.
  - On that same edge, go to DONE and register p = neg ? -acc : acc, computed modulo 2^(2*WIDTH).
- DONE:
  - out_valid = 1; p and out_valid stay stable until out_ready = 1.
  - On out_valid & out_ready, go to IDLE with out_valid = 0.
  - No new operand is accepted on that handshake edge.
- Inputs a, b, is_signed and in_valid are ignored outside IDLE.
- out_ready is ignored outside DONE.
- Arithmetic:
  - Unsigned: p = a*b; maximum (2^WIDTH - 1)^2, which never overflows.
  - Signed: p is the exact 2*WIDTH-bit two's-complement product and never overflows; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits.
- Zero operands use no early exit; latency is fixed.
- Counter width: $clog2(WIDTH+1) bits.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, p = 0, accumulator and counter = 0.
- rst_n low mid-operation aborts immediately and asynchronously to the reset values. The in-flight product is discarded and no out_valid pulse follows.
- Accept on edge E0. RUN occupies cycles E0..E0+WIDTH. out_valid is first high after edge E0+WIDTH, giving a latency of WIDTH cycles.
- With out_ready held high, each operation costs WIDTH+2 cycles from accept to the next in_ready.
- in_ready is 0 from the accept edge until the cycle after the output handshake.
- busy = 1 exactly for WIDTH cycles per operation.
- p keeps its last value after the output handshake until the next DONE entry. Only out_valid qualifies p.

## Test plan
- Reset, then WIDTH=8, unsigned 255*255 -> out_valid exactly 8 cycles after accept, p = 16'hFE01, busy high 8 cycles.
- Signed, WIDTH=8:
  - -128*-128 -> p = 16'h4000.
  - -128*127 -> p = 16'hC080.
  - 3*-5 -> p = 16'hFFF1.
  - 0*-1 -> p = 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid.
  - Required: p and out_valid stay stable and in_ready stays 0.
  - A different a/b driven with in_valid=1 during the stall is ignored; the held result is unchanged.
- Back-to-back with out_ready=1 and in_valid=1 continuous: accepts occur every 10 cycles (WIDTH+2).
- Reset mid-RUN: assert rst_n=0 on the 4th RUN cycle.
  - Required: outputs return to reset values immediately, with no spurious out_valid.
  - The next operation, 7*6, gives p = 42.
- Randomised sweep at WIDTH=4 and WIDTH=16, both modes, checked against a reference product; includes every corner of all-zeros, all-ones and the MSB-only operand.
